// File: rtl/core_decode_pipe.sv
// RV32I (+ optional RV32M) instruction decoder with a two-entry output/skid buffer.
// in_ready is the registered "skid empty" flag, so it never depends combinationally on out_ready.
module core_decode_pipe #(
  parameter int XLEN = 32,
  parameter bit EN_M = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      rd_num,
  output logic [4:0]      rs1_num,
  output logic [4:0]      rs2_num,
  output logic [XLEN-1:0] imm,
  output logic [5:0]      op,
  output logic            illegal
);

  typedef struct packed {
    logic [5:0]      op;
    logic            illegal;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
  } dec_t;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SH} fmt_e;

  localparam logic [5:0] OP_ILL = 6'd63;

  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [5:0]  op_c;
  fmt_e        fmt_c;
  logic [31:0] imm32;
  dec_t        dec;

  assign f3 = inst[14:12];
  assign f7 = inst[31:25];

  always_comb begin
    op_c  = OP_ILL;
    fmt_c = FMT_R;
    case (inst[6:0])
      7'b0110111: begin op_c = 6'd0; fmt_c = FMT_U; end
      7'b0010111: begin op_c = 6'd1; fmt_c = FMT_U; end
      7'b1101111: begin op_c = 6'd2; fmt_c = FMT_J; end
      7'b1100111: begin
        fmt_c = FMT_I;
        if (f3 == 3'b000) op_c = 6'd3;
      end
      7'b1100011: begin
        fmt_c = FMT_B;
        case (f3)
          3'b000:  op_c = 6'd4;
          3'b001:  op_c = 6'd5;
          3'b100:  op_c = 6'd6;
          3'b101:  op_c = 6'd7;
          3'b110:  op_c = 6'd8;
          3'b111:  op_c = 6'd9;
          default: op_c = OP_ILL;
        endcase
      end
      7'b0000011: begin
        fmt_c = FMT_I;
        case (f3)
          3'b000:  op_c = 6'd10;
          3'b001:  op_c = 6'd11;
          3'b010:  op_c = 6'd12;
          3'b100:  op_c = 6'd13;
          3'b101:  op_c = 6'd14;
          default: op_c = OP_ILL;
        endcase
      end
      7'b0100011: begin
        fmt_c = FMT_S;
        case (f3)
          3'b000:  op_c = 6'd15;
          3'b001:  op_c = 6'd16;
          3'b010:  op_c = 6'd17;
          default: op_c = OP_ILL;
        endcase
      end
      7'b0010011: begin
        fmt_c = FMT_I;
        case (f3)
          3'b000: op_c = 6'd18;
          3'b010: op_c = 6'd19;
          3'b011: op_c = 6'd20;
          3'b100: op_c = 6'd21;
          3'b110: op_c = 6'd22;
          3'b111: op_c = 6'd23;
          3'b001: begin
            fmt_c = FMT_SH;
            if (f7 == 7'b0000000) op_c = 6'd24;
          end
          default: begin
            fmt_c = FMT_SH;
            if (f7 == 7'b0000000)      op_c = 6'd25;
            else if (f7 == 7'b0100000) op_c = 6'd26;
          end
        endcase
      end
      7'b0110011: begin
        fmt_c = FMT_R;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  op_c = 6'd27;
            3'b001:  op_c = 6'd29;
            3'b010:  op_c = 6'd30;
            3'b011:  op_c = 6'd31;
            3'b100:  op_c = 6'd32;
            3'b101:  op_c = 6'd33;
            3'b110:  op_c = 6'd35;
            default: op_c = 6'd36;
          endcase
        end else if (f7 == 7'b0100000) begin
          if (f3 == 3'b000)      op_c = 6'd28;
          else if (f3 == 3'b101) op_c = 6'd34;
        end else if (f7 == 7'b0000001 && EN_M) begin
          // MUL..REMU follow funct3 order
          op_c = 6'd37 + {3'b000, f3};
        end
      end
      default: op_c = OP_ILL;
    endcase
  end

  always_comb begin
    imm32 = 32'd0;
    case (fmt_c)
      FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   imm32 = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   imm32 = {inst[31:12], 12'd0};
      FMT_J:   imm32 = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      FMT_SH:  imm32 = {27'd0, inst[24:20]};
      default: imm32 = 32'd0;
    endcase
  end

  always_comb begin
    dec = '0;
    if (op_c == OP_ILL) begin
      dec.op      = OP_ILL;
      dec.illegal = 1'b1;
    end else begin
      dec.op  = op_c;
      dec.imm = {XLEN{imm32[31]}};
      dec.imm[31:0] = imm32;
      if (fmt_c != FMT_S && fmt_c != FMT_B)
        dec.rd = inst[11:7];
      if (fmt_c != FMT_U && fmt_c != FMT_J)
        dec.rs1 = inst[19:15];
      if (fmt_c == FMT_R || fmt_c == FMT_S || fmt_c == FMT_B)
        dec.rs2 = inst[24:20];
    end
  end

  dec_t out_q, out_d, skid_q, skid_d;
  logic out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic accept;

  assign accept = in_valid && !skid_vld_q && !flush;

  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!out_vld_q || out_ready) begin
      // A full skid blocks in_ready, so refill and accept never coincide
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        out_d     = dec;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_d     = dec;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign in_ready  = !skid_vld_q;
  assign out_valid = out_vld_q;
  assign rd_num    = out_q.rd;
  assign rs1_num   = out_q.rs1;
  assign rs2_num   = out_q.rs2;
  assign imm       = out_q.imm;
  assign op        = out_q.op;
  assign illegal   = out_q.illegal;

endmodule
